// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer blit controller.
// Frame geometry (208 x 84 five-bit palette indices, linear address y*FB_W+x),
// sprite ROM geometry, command opcode, FSM state encoding and the latched
// command record.
package fb_pkg;
    localparam int FB_W       = 208;
    localparam int FB_H       = 84;
    localparam int FB_AW      = 15;
    localparam int FB_WORDS   = FB_W * FB_H;
    localparam int ROM_AW     = 13;
    localparam int SRC_STRIDE = 64;

    typedef enum logic {
        FB_CLEAR = 1'b0,
        FB_BLIT  = 1'b1
    } fb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_BLIT,
        ST_DRAIN,
        ST_DONE
    } blit_state_e;

    typedef struct packed {
        fb_op_e              op;
        logic [7:0]          x;
        logic [6:0]          y;
        logic [5:0]          w;
        logic [5:0]          h;
        logic [ROM_AW-1:0]   src_base;
        logic [4:0]          color;
    } fb_cmd_t;
endpackage

// File: rtl/fb_addr_gen.sv
// Pixel address generator for the blit controller.
// Walks a w_lim x h_lim rectangle in row-major order (column i, row j), one
// pixel per 'step'. Produces the sprite ROM read address for the current
// pixel, the unclipped destination address (combinational, used by CLEAR),
// and a one-stage registered copy of destination address, clip flag and
// valid that lines up with the ROM's one-cycle read latency.
// Ports:
//   Clk, Reset         clock, synchronous active-high reset
//   start              zero the counters (command accepted)
//   step               advance to the next pixel
//   pipe_en            the stepped pixel is a ROM-sourced pixel (BLIT)
//   x, y               destination of the rectangle's top-left corner
//   w_lim, h_lim       rectangle size
//   src_base           ROM address of the source top-left
//   rom_addr           ROM read address of the current pixel
//   last               current pixel is the bottom-right one
//   dest_p0            destination address of the current pixel
//   dest_p1/clip_p1/vld_p1  registered destination, clip and valid
module fb_addr_gen
    import fb_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              step,
    input  logic              pipe_en,
    input  logic [7:0]        x,
    input  logic [6:0]        y,
    input  logic [7:0]        w_lim,
    input  logic [6:0]        h_lim,
    input  logic [ROM_AW-1:0] src_base,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              last,
    output logic [FB_AW-1:0]  dest_p0,
    output logic [FB_AW-1:0]  dest_p1,
    output logic              clip_p1,
    output logic              vld_p1
);
    logic [7:0] i;
    logic [6:0] j;
    logic [8:0] dx;
    logic [7:0] dy;
    logic       clip_p0;

    // One extra bit on each coordinate sum so a sprite hanging past the
    // right/bottom edge is detected instead of wrapping back on screen.
    assign dx      = {1'b0, x} + {1'b0, i};
    assign dy      = {1'b0, y} + {1'b0, j};
    assign clip_p0 = (dx >= 9'(FB_W)) || (dy >= 8'(FB_H));
    assign dest_p0 = clip_p0 ? '0 : (FB_AW'(dy) * FB_AW'(FB_W)) + FB_AW'(dx);

    // Sprite sheet address wraps modulo the ROM size.
    assign rom_addr = src_base + ROM_AW'(j) * ROM_AW'(SRC_STRIDE) + ROM_AW'(i);
    assign last     = (i == w_lim - 8'd1) && (j == h_lim - 7'd1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            i      <= '0;
            j      <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= step && pipe_en;
            if (start) begin
                i <= '0;
                j <= '0;
            end else if (step) begin
                if (i == w_lim - 8'd1) begin
                    i <= '0;
                    j <= j + 7'd1;
                end else begin
                    i <= i + 8'd1;
                end
            end
        end
    end

    // p0 -> p1: destination travels alongside the outstanding ROM read
    always_ff @(posedge Clk) begin
        dest_p1 <= dest_p0;
        clip_p1 <= clip_p0;
    end
endmodule

// File: rtl/fb_blit_controller.sv
// Frame-buffer write sequencer.
// Accepts CLEAR (fill the whole frame with one index) or BLIT (copy a WxH
// sprite from ROM, index 0 transparent, off-screen pixels clipped) commands
// over a valid/ready handshake and drives the frame buffer write port at one
// pixel per cycle.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; ready only while idle
//   cmd_op                0=CLEAR, 1=BLIT
//   cmd_x, cmd_y          destination top-left
//   cmd_w, cmd_h          blit size (0 means no pixels)
//   cmd_src_base          ROM address of sprite top-left
//   cmd_color             CLEAR fill index
//   rom_addr, rom_data    sprite ROM read port (1-cycle latency)
//   fb_we, fb_write_address, fb_data_In   frame buffer write port
//   busy                  command in progress
//   done                  one-cycle pulse after the last write
module fb_blit_controller
    import fb_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [7:0]        cmd_x,
    input  logic [6:0]        cmd_y,
    input  logic [5:0]        cmd_w,
    input  logic [5:0]        cmd_h,
    input  logic [ROM_AW-1:0] cmd_src_base,
    input  logic [4:0]        cmd_color,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [4:0]        rom_data,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_write_address,
    output logic [4:0]        fb_data_In,
    output logic              busy,
    output logic              done
);
    blit_state_e      state;
    fb_cmd_t          cmd_q;
    logic             accept;
    logic             is_clear;
    logic             empty;
    logic             step;
    logic             pipe_en;
    logic             last;
    logic [7:0]       w_lim;
    logic [6:0]       h_lim;
    logic [7:0]       x_org;
    logic [6:0]       y_org;
    logic [FB_AW-1:0] dest_p0;
    logic [FB_AW-1:0] dest_p1;
    logic             clip_p1;
    logic             vld_p1;

    assign accept   = cmd_valid && cmd_ready;
    assign is_clear = (cmd_q.op == FB_CLEAR);
    assign empty    = (cmd_q.w == 6'd0) || (cmd_q.h == 6'd0);

    // CLEAR reuses the rectangle walker as a full-screen rectangle at (0,0),
    // which yields the linear addresses 0..FB_WORDS-1 in order.
    assign w_lim = is_clear ? 8'(FB_W) : {2'b00, cmd_q.w};
    assign h_lim = is_clear ? 7'(FB_H) : {1'b0, cmd_q.h};
    assign x_org = is_clear ? 8'd0 : cmd_q.x;
    assign y_org = is_clear ? 7'd0 : cmd_q.y;

    assign step    = (state == ST_CLEAR) || ((state == ST_BLIT) && !empty);
    assign pipe_en = (state == ST_BLIT);

    fb_addr_gen u_addr_gen (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (accept),
        .step     (step),
        .pipe_en  (pipe_en),
        .x        (x_org),
        .y        (y_org),
        .w_lim    (w_lim),
        .h_lim    (h_lim),
        .src_base (cmd_q.src_base),
        .rom_addr (rom_addr),
        .last     (last),
        .dest_p0  (dest_p0),
        .dest_p1  (dest_p1),
        .clip_p1  (clip_p1),
        .vld_p1   (vld_p1)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state            <= ST_IDLE;
            cmd_q            <= '0;
            cmd_ready        <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            fb_we            <= 1'b0;
            fb_write_address <= '0;
            fb_data_In       <= '0;
        end else begin
            done  <= 1'b0;
            fb_we <= 1'b0;

            // p1 -> write stage: ROM data has arrived for the pixel in p1
            if ((state == ST_BLIT) || (state == ST_DRAIN)) begin
                fb_we            <= vld_p1 && (rom_data != 5'd0) && !clip_p1;
                fb_write_address <= dest_p1;
                fb_data_In       <= rom_data;
            end

            case (state)
                ST_IDLE: begin
                    // Ready returns one cycle after the done pulse.
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (accept) begin
                        cmd_q <= '{op: fb_op_e'(cmd_op), x: cmd_x, y: cmd_y,
                                   w: cmd_w, h: cmd_h, src_base: cmd_src_base,
                                   color: cmd_color};
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= cmd_op ? ST_BLIT : ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    fb_we            <= 1'b1;
                    fb_write_address <= dest_p0;
                    fb_data_In       <= cmd_q.color;
                    if (last) state <= ST_DONE;
                end
                ST_BLIT: begin
                    if (empty)     state <= ST_DONE;
                    else if (last) state <= ST_DRAIN;
                end
                ST_DRAIN: state <= ST_DONE;
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_blit_controller.sv
// Bench for fb_blit_controller: directed commands, a per-command expected
// write schedule built from the pixel rules, a cycle-by-cycle compare of the
// write port / handshake, and literal expectations for the directed cases.
module tb_fb_blit_controller;
    import fb_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [7:0]        cmd_x;
    logic [6:0]        cmd_y;
    logic [5:0]        cmd_w;
    logic [5:0]        cmd_h;
    logic [ROM_AW-1:0] cmd_src_base;
    logic [4:0]        cmd_color;
    logic [ROM_AW-1:0] rom_addr;
    logic [4:0]        rom_data;
    logic              fb_we;
    logic [FB_AW-1:0]  fb_write_address;
    logic [4:0]        fb_data_In;
    logic              busy;
    logic              done;

    fb_blit_controller dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_x            (cmd_x),
        .cmd_y            (cmd_y),
        .cmd_w            (cmd_w),
        .cmd_h            (cmd_h),
        .cmd_src_base     (cmd_src_base),
        .cmd_color        (cmd_color),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .fb_we            (fb_we),
        .fb_write_address (fb_write_address),
        .fb_data_In       (fb_data_In),
        .busy             (busy),
        .done             (done)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM with one cycle of read latency
    logic [4:0] rom [0:8191];
    always @(posedge Clk) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // Expected schedule, keyed by cycles after the accept edge
    int exp_addr [int];
    int exp_dat  [int];
    int done_rel;
    int acc_cyc;
    bit active = 1'b0;
    int wr_total = 0;
    int rel_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    // Compare process: every cycle outside reset
    initial begin
        forever begin
            @(negedge Clk);
            if (Reset === 1'b0) begin
                if (fb_we === 1'b1) wr_total++;
                if (active) begin
                    rel_c = cyc - acc_cyc;
                    if (rel_c >= 0 && rel_c <= done_rel + 1) begin
                        chk("fb_we", fb_we, exp_addr.exists(rel_c) ? 1 : 0);
                        if (fb_we === 1'b1 && exp_addr.exists(rel_c)) begin
                            chk("fb_addr", fb_write_address, exp_addr[rel_c]);
                            chk("fb_data", fb_data_In, exp_dat[rel_c]);
                        end
                        chk("done", done, (rel_c == done_rel) ? 1 : 0);
                        chk("cmd_ready", cmd_ready, (rel_c > done_rel) ? 1 : 0);
                        chk("busy", busy, (rel_c <= done_rel) ? 1 : 0);
                    end
                end else begin
                    chk("idle_fb_we", fb_we, 0);
                    chk("idle_done", done, 0);
                end
            end
        end
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    // Build the expected write schedule from the pixel rules, then present
    // the command and wait (bounded) until it is taken.
    task automatic start_cmd(input bit op, input int x, input int y, input int w,
                             input int h, input int base, input int color);
        int n;
        exp_addr.delete();
        exp_dat.delete();
        if (!op) begin
            for (int k = 0; k < FB_WORDS; k++) begin
                exp_addr[k+1] = k;
                exp_dat[k+1]  = color;
            end
            done_rel = FB_WORDS + 1;
        end else begin
            for (int jj = 0; jj < h; jj++) begin
                for (int ii = 0; ii < w; ii++) begin
                    int k;
                    int px;
                    int py;
                    int ra;
                    k  = jj * w + ii;
                    px = x + ii;
                    py = y + jj;
                    ra = (base + jj * SRC_STRIDE + ii) % 8192;
                    if (px < FB_W && py < FB_H && rom[ra] != 5'd0) begin
                        exp_addr[k+2] = py * FB_W + px;
                        exp_dat[k+2]  = int'(rom[ra]);
                    end
                end
            end
            done_rel = w * h + 2;
        end
        cmd_op       = op;
        cmd_x        = 8'(x);
        cmd_y        = 7'(y);
        cmd_w        = 6'(w);
        cmd_h        = 6'(h);
        cmd_src_base = ROM_AW'(base);
        cmd_color    = 5'(color);
        cmd_valid    = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
        end else begin
            acc_cyc = cyc + 1;
            active  = 1'b1;
            @(posedge Clk);
            #1;
            // Inputs must be ignored while busy
            cmd_valid    = 1'b0;
            cmd_op       = 1'($urandom);
            cmd_x        = 8'($urandom);
            cmd_y        = 7'($urandom);
            cmd_w        = 6'($urandom);
            cmd_h        = 6'($urandom);
            cmd_src_base = ROM_AW'($urandom);
            cmd_color    = 5'($urandom);
        end
    endtask

    // Returns on the cycle cmd_ready is expected back.
    task automatic wait_done(input int n_writes, input string name);
        int wr0;
        wr0 = wr_total;
        if (active) begin
            while (cyc - acc_cyc < done_rel + 1) tick();
            chk(name, wr_total - wr0, n_writes);
            active = 1'b0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before summary, expected completion");
        $fatal(1);
    end

    initial begin
        int wr_start;
        Reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_op       = 1'b0;
        cmd_x        = '0;
        cmd_y        = '0;
        cmd_w        = '0;
        cmd_h        = '0;
        cmd_src_base = '0;
        cmd_color    = '0;
        for (int a = 0; a < 8192; a++) rom[a] = 5'd3;

        // Reset values
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_fb_addr", fb_write_address, 0);
        chk("rst_fb_data", fb_data_In, 0);
        Reset = 1'b0;
        tick();

        // Reset held 3 cycles in the middle of a CLEAR
        start_cmd(1'b0, 0, 0, 0, 0, 0, 9);
        repeat (40) tick();
        Reset  = 1'b1;
        active = 1'b0;
        repeat (3) begin
            tick();
            chk("abort_fb_we", fb_we, 0);
            chk("abort_done", done, 0);
        end
        Reset = 1'b0;
        wr_start = wr_total;
        tick();
        chk("abort_fb_we_after", fb_we, 0);
        chk("abort_ready_after", cmd_ready, 1);
        chk("abort_busy_after", busy, 0);
        chk("abort_rom_addr", rom_addr, 0);
        repeat (10) tick();
        chk("abort_no_writes", wr_total - wr_start, 0);

        // Full-screen CLEAR with color 5
        start_cmd(1'b0, 0, 0, 0, 0, 0, 5);
        chk("model_clear_done", done_rel, 17473);
        chk("model_clear_last", exp_addr[17472], 17471);
        wait_done(17472, "clear_writes");

        // BLIT 4x2 at (10,2), ROM all 3
        start_cmd(1'b1, 10, 2, 4, 2, 0, 0);
        chk("model_b1_done", done_rel, 10);
        chk("model_b1_first", exp_addr[2], 426);
        chk("model_b1_last", exp_addr[9], 637);
        wait_done(8, "blit1_writes");

        // Transparent middle pixel
        rom[100] = 5'd7;
        rom[101] = 5'd0;
        rom[102] = 5'd9;
        start_cmd(1'b1, 20, 5, 3, 1, 100, 0);
        chk("model_b2_p0", exp_addr[2], 1060);
        chk("model_b2_skip", exp_addr.exists(3) ? 1 : 0, 0);
        chk("model_b2_p2", exp_addr[4], 1062);
        wait_done(2, "blit2_writes");

        // Clipped at the bottom-right corner
        start_cmd(1'b1, 206, 83, 4, 2, 0, 0);
        chk("model_b3_count", exp_addr.num(), 2);
        chk("model_b3_a", exp_addr[2], 17470);
        chk("model_b3_b", exp_addr[3], 17471);
        chk("model_b3_done", done_rel, 10);
        wait_done(2, "blit3_writes");

        // Varied data with the ROM address wrapping past 8191
        for (int a = 0; a < 8192; a++) rom[a] = 5'((a * 7 + 3) % 32);
        start_cmd(1'b1, 100, 40, 5, 3, 8190, 0);
        chk("model_b4_first", exp_dat[2], 21);
        chk("model_b4_wrap", exp_dat[4], 3);
        wait_done(15, "blit4_writes");

        // Empty BLIT, then a command held valid during busy
        for (int a = 0; a < 8192; a++) rom[a] = 5'd3;
        start_cmd(1'b1, 50, 10, 0, 5, 0, 0);
        chk("model_b5_done", done_rel, 2);
        cmd_op       = 1'b1;
        cmd_x        = 8'd0;
        cmd_y        = 7'd0;
        cmd_w        = 6'd2;
        cmd_h        = 6'd1;
        cmd_src_base = '0;
        cmd_color    = 5'd0;
        cmd_valid    = 1'b1;
        wait_done(0, "blit5_writes");
        start_cmd(1'b1, 0, 0, 2, 1, 0, 0);
        wait_done(2, "blit6_writes");

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
